verdict_tracker: RTL and testbench

VERDICT_TRACKER -- requirements
Module: verdict_tracker

---
 rtl/verdict_tracker.sv | 179 +++++++++++++++++
 tb/tb_verdict_tracker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/verdict_tracker.sv
// -----------------------------------------------------------------------------
// verdict_tracker
//   Tracks one checking run that compares two cores. It counts cycles and
//   retirements while the run is live and records where the attacker-visible
//   observations first diverged. It then settles on a verdict: SAFE, LEAK,
//   DISCARD (the contract observations differed, so the run proves nothing)
//   or TIMEOUT.
//
// Parameters
//   CNT_W       width of every counter and capture output
//   MAX_CYCLES  run length in clk_i cycles after which an unfinished run
//               times out
//
// Ports
//   clk_i          sole clock
//   rst_ni         asynchronous active-low reset
//   start_i        pulse that begins a new run (ignored while busy)
//   retire_i       synchronized retirement pulse
//   ctr_equiv_i    contract observations of both cores equal so far
//   atk_equiv_i    attacker observations of both cores equal this cycle
//   finished_i     both programs complete
//   state_o        current state code (IDLE=0 .. TIMEOUT=6)
//   busy_o         run in progress (RUN or PEND)
//   done_o         a verdict has been reached
//   leak_o         verdict is LEAK
//   cycle_cnt_o    cycles elapsed in the current run
//   retire_cnt_o   retire_i pulses in the current run
//   leak_cycle_o   cycle count at the first attacker divergence
//   leak_retire_o  retire count at the first attacker divergence
// -----------------------------------------------------------------------------
module verdict_tracker #(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             retire_i,
  input  logic             ctr_equiv_i,
  input  logic             atk_equiv_i,
  input  logic             finished_i,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             leak_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [CNT_W-1:0] leak_cycle_o,
  output logic [CNT_W-1:0] leak_retire_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PEND    = 3'd2,
    S_LEAK    = 3'd3,
    S_SAFE    = 3'd4,
    S_DISCARD = 3'd5,
    S_TIMEOUT = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LP_LAST    = CNT_W'(MAX_CYCLES - 1);
  // If the counter cannot represent MAX_CYCLES-1, it saturates first and the
  // run can never time out. A truncated compare would fire early instead.
  localparam bit               LP_FITS    = ($clog2(MAX_CYCLES) <= CNT_W);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_busy;
  logic             r_done;
  logic             r_leak;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_leak_cycle;
  logic [CNT_W-1:0] r_leak_retire;

  logic w_clear;
  logic w_capture;
  logic w_counting;
  logic w_at_limit;
  logic w_next_busy;
  logic w_next_done;

  assign w_counting = (r_state == S_RUN) || (r_state == S_PEND);
  assign w_at_limit = LP_FITS && (r_cycle_cnt == LP_LAST);

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE, S_LEAK, S_SAFE, S_DISCARD, S_TIMEOUT: begin
        if (start_i) begin
          w_state_next = S_RUN;
          w_clear      = 1'b1;
        end
      end
      S_RUN: begin
        // A contract divergence outranks everything, so a simultaneous
        // attacker divergence is never captured.
        if (!ctr_equiv_i) begin
          w_state_next = S_DISCARD;
        end else if (!atk_equiv_i) begin
          w_state_next = S_PEND;
          w_capture    = 1'b1;
        end else if (finished_i) begin
          w_state_next = S_SAFE;
        end else if (w_at_limit) begin
          w_state_next = S_TIMEOUT;
        end
      end
      S_PEND: begin
        // The capture stays as taken on entry. Later attacker divergences
        // are irrelevant here.
        if (!ctr_equiv_i) begin
          w_state_next = S_DISCARD;
        end else if (finished_i) begin
          w_state_next = S_LEAK;
        end else if (w_at_limit) begin
          w_state_next = S_TIMEOUT;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_next_busy = (w_state_next == S_RUN) || (w_state_next == S_PEND);
  assign w_next_done = (w_state_next == S_LEAK) || (w_state_next == S_SAFE) ||
                       (w_state_next == S_DISCARD) || (w_state_next == S_TIMEOUT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_leak        <= 1'b0;
      r_cycle_cnt   <= '0;
      r_retire_cnt  <= '0;
      r_leak_cycle  <= '0;
      r_leak_retire <= '0;
    end else begin
      r_state <= w_state_next;
      // Flags are decoded from the next state so they line up with state_o.
      r_busy  <= w_next_busy;
      r_done  <= w_next_done;
      r_leak  <= (w_state_next == S_LEAK);
      if (w_clear) begin
        r_cycle_cnt   <= '0;
        r_retire_cnt  <= '0;
        r_leak_cycle  <= '0;
        r_leak_retire <= '0;
      end else if (w_counting) begin
        if (r_cycle_cnt != LP_CNT_MAX) begin
          r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
        if (retire_i && (r_retire_cnt != LP_CNT_MAX)) begin
          r_retire_cnt <= r_retire_cnt + 1'b1;
        end
        // Pre-increment values: where the divergence was observed.
        if (w_capture) begin
          r_leak_cycle  <= r_cycle_cnt;
          r_leak_retire <= r_retire_cnt;
        end
      end
    end
  end

  assign state_o       = r_state;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign leak_o        = r_leak;
  assign cycle_cnt_o   = r_cycle_cnt;
  assign retire_cnt_o  = r_retire_cnt;
  assign leak_cycle_o  = r_leak_cycle;
  assign leak_retire_o = r_leak_retire;

endmodule

// File: tb/tb_verdict_tracker.sv
// -----------------------------------------------------------------------------
// tb_verdict_tracker
//   Three verdict_tracker instances share one stimulus stream:
//     u0: CNT_W=16, MAX_CYCLES=20  (main directed scenarios)
//     u1: CNT_W=16, MAX_CYCLES=8   (timeout scenario)
//     u2: CNT_W=3,  MAX_CYCLES=100 (counter saturation, no reachable timeout)
//   A per-instance run model is stepped on each clock edge. Every output of
//   every instance is compared against it after each edge. Directed
//   scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_verdict_tracker;

  localparam int N = 3;
  localparam int MAXC[N] = '{20, 8, 100};
  localparam int SAT[N]  = '{65535, 65535, 7};

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic start_i = 1'b0, retire_i = 1'b0, finished_i = 1'b0;
  logic ctr_equiv_i = 1'b1, atk_equiv_i = 1'b1;

  always #5 clk_i = ~clk_i;

  logic [2:0]  st0, st1, st2;
  logic        b0, b1, b2, d0, d1, d2, l0, l1, l2;
  logic [15:0] cc0, cc1, rc0, rc1, lc0, lc1, lr0, lr1;
  logic [2:0]  cc2, rc2, lc2, lr2;

  verdict_tracker #(.CNT_W(16), .MAX_CYCLES(20)) u0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .retire_i(retire_i),
    .ctr_equiv_i(ctr_equiv_i), .atk_equiv_i(atk_equiv_i), .finished_i(finished_i),
    .state_o(st0), .busy_o(b0), .done_o(d0), .leak_o(l0), .cycle_cnt_o(cc0),
    .retire_cnt_o(rc0), .leak_cycle_o(lc0), .leak_retire_o(lr0));

  verdict_tracker #(.CNT_W(16), .MAX_CYCLES(8)) u1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .retire_i(retire_i),
    .ctr_equiv_i(ctr_equiv_i), .atk_equiv_i(atk_equiv_i), .finished_i(finished_i),
    .state_o(st1), .busy_o(b1), .done_o(d1), .leak_o(l1), .cycle_cnt_o(cc1),
    .retire_cnt_o(rc1), .leak_cycle_o(lc1), .leak_retire_o(lr1));

  verdict_tracker #(.CNT_W(3), .MAX_CYCLES(100)) u2 (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .retire_i(retire_i),
    .ctr_equiv_i(ctr_equiv_i), .atk_equiv_i(atk_equiv_i), .finished_i(finished_i),
    .state_o(st2), .busy_o(b2), .done_o(d2), .leak_o(l2), .cycle_cnt_o(cc2),
    .retire_cnt_o(rc2), .leak_cycle_o(lc2), .leak_retire_o(lr2));

  // Reference model: the verdict reached so far plus the run statistics.
  int m_st[N], m_cyc[N], m_ret[N], m_lc[N], m_lr[N];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int lim);
    return (v < lim) ? v + 1 : lim;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_st[i] = 0; m_cyc[i] = 0; m_ret[i] = 0; m_lc[i] = 0; m_lr[i] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == 1 || m_st[i] == 2) begin
        int nxt = m_st[i];
        if (!ctr_equiv_i) nxt = 5;
        else if (m_st[i] == 1 && !atk_equiv_i) begin
          nxt = 2; m_lc[i] = m_cyc[i]; m_lr[i] = m_ret[i];
        end
        else if (finished_i) nxt = (m_st[i] == 1) ? 4 : 3;
        else if (m_cyc[i] == MAXC[i] - 1) nxt = 6;
        m_cyc[i] = sat_inc(m_cyc[i], SAT[i]);
        if (retire_i) m_ret[i] = sat_inc(m_ret[i], SAT[i]);
        m_st[i] = nxt;
      end else if (start_i) begin
        m_st[i] = 1; m_cyc[i] = 0; m_ret[i] = 0; m_lc[i] = 0; m_lr[i] = 0;
      end
    end
  endfunction

  task automatic check_inst(input int i, input logic [2:0] st, input logic b,
                            input logic d, input logic l, input logic [15:0] c,
                            input logic [15:0] r, input logic [15:0] lc, input logic [15:0] lr);
    chk($sformatf("u%0d state", i), 32'(st), m_st[i]);
    chk($sformatf("u%0d busy", i), 32'(b), 32'(m_st[i] == 1 || m_st[i] == 2));
    chk($sformatf("u%0d done", i), 32'(d), 32'(m_st[i] >= 3 && m_st[i] <= 6));
    chk($sformatf("u%0d leak", i), 32'(l), 32'(m_st[i] == 3));
    chk($sformatf("u%0d cycle_cnt", i), 32'(c), m_cyc[i]);
    chk($sformatf("u%0d retire_cnt", i), 32'(r), m_ret[i]);
    chk($sformatf("u%0d leak_cycle", i), 32'(lc), m_lc[i]);
    chk($sformatf("u%0d leak_retire", i), 32'(lr), m_lr[i]);
  endtask

  task automatic check_all();
    check_inst(0, st0, b0, d0, l0, cc0, rc0, lc0, lr0);
    check_inst(1, st1, b1, d1, l1, cc1, rc1, lc1, lr1);
    check_inst(2, st2, b2, d2, l2, {13'd0, cc2}, {13'd0, rc2}, {13'd0, lc2}, {13'd0, lr2});
  endtask

  // Drive one cycle's inputs, let the edge happen, then compare.
  task automatic step(input logic s, input logic r, input logic c,
                      input logic a, input logic f);
    start_i = s; retire_i = r; ctr_equiv_i = c; atk_equiv_i = a; finished_i = f;
    @(posedge clk_i);
    if (rst_ni) model_step();
    else model_reset();
    #1;
    check_all();
  endtask

  // Assert reset between edges and check that it takes effect immediately.
  task automatic async_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    model_reset();
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(0, 0, 1, 1, 0);
    chk("reset state", 32'(st0), 0);
    $display("scenario reset/idle");

    // Safe run: 5 retires, finished at cycle 9.
    step(1, 0, 1, 1, 0);
    for (int c = 0; c <= 9; c++) step(0, (c >= 1 && c <= 5), 1, 1, (c == 9));
    chk("safe state", 32'(st0), 4);
    chk("safe done", 32'(d0), 1);
    chk("safe leak", 32'(l0), 0);
    chk("safe retires", 32'(rc0), 5);
    $display("scenario safe run");

    // Leak: atk diverges at cycle 3 after 2 retires, finished at cycle 7.
    step(1, 0, 1, 1, 0);
    for (int c = 0; c <= 7; c++) step(0, (c <= 1), 1, (c != 3), (c == 7));
    chk("leak state", 32'(st0), 3);
    chk("leak flag", 32'(l0), 1);
    chk("leak cycle", 32'(lc0), 3);
    chk("leak retire", 32'(lr0), 2);
    $display("scenario leak");

    // Discard after pending: atk diverges at 2, ctr diverges at 4.
    step(1, 0, 1, 1, 0);
    for (int c = 0; c <= 4; c++) step(0, 0, (c != 4), (c != 2), 0);
    chk("discard state", 32'(st0), 5);
    chk("discard leak", 32'(l0), 0);
    $display("scenario discard after pending");

    // Simultaneous divergence at cycle 3 with a retire already counted.
    step(1, 0, 1, 1, 0);
    for (int c = 0; c <= 3; c++) step(0, (c == 0), (c != 3), (c != 3), 0);
    chk("simul state", 32'(st0), 5);
    chk("simul leak_cycle", 32'(lc0), 0);
    chk("simul leak_retire", 32'(lr0), 0);
    $display("scenario simultaneous divergence");

    // Timeout on u1 (MAX_CYCLES=8); u0 keeps running and ignores start.
    step(1, 0, 1, 1, 0);
    for (int c = 0; c <= 7; c++) step(0, 0, 1, 1, 0);
    chk("timeout state", 32'(st1), 6);
    chk("timeout cycles", 32'(cc1), 8);
    step(1, 1, 1, 1, 0);
    chk("restart state", 32'(st1), 1);
    chk("restart cycles", 32'(cc1), 0);
    chk("restart retires", 32'(rc1), 0);
    chk("busy start ignored state", 32'(st0), 1);
    chk("busy start ignored cycles", 32'(cc0), 9);
    $display("scenario timeout and restart");

    // Reset mid-PEND, then stay idle without start.
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("pend state", 32'(st0), 2);
    async_reset();
    chk("reset mid-pend state", 32'(st0), 0);
    chk("reset mid-pend cycles", 32'(cc0), 0);
    chk("reset mid-pend leak_cycle", 32'(lc0), 0);
    for (int c = 0; c < 3; c++) step(0, 1, 0, 0, 1);
    chk("idle after reset", 32'(st0), 0);
    $display("scenario reset mid-pend");

    // Randomized runs, with inputs toggling in every state.
    for (int run = 0; run < 40; run++) begin
      step(1, 0, 1, 1, 0);
      for (int k = 0; k < int'($urandom_range(5, 30)); k++) begin
        step(($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 39) != 0), ($urandom_range(0, 14) != 0),
             ($urandom_range(0, 19) == 0));
        if ($urandom_range(0, 199) == 0) async_reset();
      end
      $display("random run %0d: u0 state %0d cycles %0d", run, st0, cc0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
